// File: rtl/ras_ckpt.sv
// Return-address stack with an in-order table of branch checkpoints for fetch.
// Optional top-entry repair on recover is enabled by defining RAS_TOS_REPAIR_EN.
module ras_ckpt #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 32,
  parameter int unsigned NCKPT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic                     pop,
  output logic [AW-1:0]            top_addr,
  output logic                     top_valid,
  input  logic                     ckpt_alloc,
  output logic                     ckpt_ready,
  output logic [$clog2(NCKPT)-1:0] ckpt_id,
  input  logic                     ckpt_free,
  input  logic                     recover,
  input  logic [$clog2(NCKPT)-1:0] recover_id,
  output logic                     overflow
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(NCKPT);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  // Stack storage and pointers
  logic [AW-1:0] stack_q [DEPTH];
  logic [PW-1:0] sp_q;
  logic [PW:0]   count_q;
  logic          overflow_q;

  // Checkpoint queue: slots plus head/tail/occupancy
  logic [PW-1:0] slot_sp_q  [NCKPT];
  logic [PW:0]   slot_cnt_q [NCKPT];
`ifdef RAS_TOS_REPAIR_EN
  logic [AW-1:0] slot_top_q [NCKPT];
`endif
  logic [CW-1:0] head_q;
  logic [CW-1:0] tail_q;
  logic [CW:0]   nck_q;

  logic [PW-1:0] sp_m1;
  logic          cnt_nz;
  logic          do_replace;
  logic          do_push;
  logic          do_pop;
  logic          free_ok;
  logic          alloc_ok;
  logic [PW-1:0] rec_sp;
  logic [PW:0]   rec_cnt;

  assign sp_m1      = sp_q - 1'b1;
  assign cnt_nz     = (count_q != '0);
  assign do_replace = push & pop & cnt_nz;
  assign do_push    = push & ~do_replace;
  assign do_pop     = pop & ~push & cnt_nz;
  assign free_ok    = ckpt_free & (nck_q != '0);
  // When full, a same-cycle free releases exactly the slot the alloc targets
  // (tail == head), so the pair is accepted and occupancy stays at NCKPT.
  assign alloc_ok   = ckpt_alloc & (~nck_q[CW] | free_ok);
  assign rec_sp     = slot_sp_q[recover_id];
  assign rec_cnt    = slot_cnt_q[recover_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stack_q[i] <= '0;
      for (int i = 0; i < int'(NCKPT); i++) begin
        slot_sp_q[i]  <= '0;
        slot_cnt_q[i] <= '0;
`ifdef RAS_TOS_REPAIR_EN
        slot_top_q[i] <= '0;
`endif
      end
      sp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      nck_q      <= '0;
    end else if (recover) begin
      // Restore pointers and drop the recovered slot plus everything younger
      sp_q    <= rec_sp;
      count_q <= rec_cnt;
      tail_q  <= recover_id;
      nck_q   <= {1'b0, recover_id - head_q};
`ifdef RAS_TOS_REPAIR_EN
      if (rec_cnt != '0) stack_q[rec_sp - 1'b1] <= slot_top_q[recover_id];
`endif
    end else begin
      if (do_replace) begin
        stack_q[sp_m1] <= push_addr;
      end else if (do_push) begin
        stack_q[sp_q] <= push_addr;
        sp_q          <= sp_q + 1'b1;
        // A full stack overwrites its oldest entry; count stays saturated
        if (count_q == FULL) overflow_q <= 1'b1;
        else                 count_q    <= count_q + 1'b1;
      end else if (do_pop) begin
        sp_q    <= sp_m1;
        count_q <= count_q - 1'b1;
      end

      if (alloc_ok) begin
        slot_sp_q[tail_q]  <= sp_q;
        slot_cnt_q[tail_q] <= count_q;
`ifdef RAS_TOS_REPAIR_EN
        slot_top_q[tail_q] <= stack_q[sp_m1];
`endif
        tail_q <= tail_q + 1'b1;
      end
      if (free_ok) head_q <= head_q + 1'b1;

      if (alloc_ok & ~free_ok)      nck_q <= nck_q + 1'b1;
      else if (free_ok & ~alloc_ok) nck_q <= nck_q - 1'b1;
    end
  end

  assign top_addr   = stack_q[sp_m1];
  assign top_valid  = cnt_nz;
  assign ckpt_ready = ~nck_q[CW];
  assign ckpt_id    = tail_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/ras_ckpt.md
# ras_ckpt

Return-address stack with an internal table of branch checkpoints, for the fetch stage of the out-of-order core. It is the successor to the single-snapshot RAS and is parametrised in depth, address width and checkpoint count. Fetch pushes on calls and pops on returns. Each predicted branch allocates an in-order checkpoint slot; commit frees slots in order. A mispredict restores the stack pointer, the count and (optionally) the top entry from the named slot, then discards that slot and all younger slots.

## Interface
- DEPTH, 16: stack entries, power of two, ≥2. PW = $clog2(DEPTH).
- AW, 32: return-address width.
- NCKPT, 8: checkpoint slots, power of two, ≥2. CW = $clog2(NCKPT).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- push  in  1  call seen; push push_addr
- push_addr  in  AW  return address to push
- pop  in  1  return seen; pop top
- top_addr  out  AW  stack[sp-1]; predicted return target
- top_valid  out  1  count != 0
- ckpt_alloc  in  1  take snapshot into slot ckpt_id
- ckpt_ready  out  1  free slot available (nck < NCKPT)
- ckpt_id  out  CW  slot that the next alloc uses (queue tail)
- ckpt_free  in  1  commit: release oldest slot (queue head)
- recover  in  1  mispredict: restore from recover_id
- recover_id  in  CW  slot to restore; must be live
- overflow  out  1  sticky; set when a push occurs at count == DEPTH; cleared by rst

## Operation
- State: stack[DEPTH] of AW bits; sp (PW bits, next free slot); count (PW+1 bits, 0..DEPTH); checkpoint queue head/tail (CW bits) and nck (CW+1 bits); each slot holds {sp, count, top}.
- Priority: rst > recover > normal.
- Normal cycle, stack side:
  - push & pop: stack[sp-1] <= push_addr (replace top). If count == 0, treat as a plain push instead.
  - push only: stack[sp] <= push_addr; sp+1 (wraps mod DEPTH); count saturates at DEPTH; at count == DEPTH the oldest entry is overwritten and overflow is set.
  - pop only: if count > 0, sp-1 and count-1. Otherwise no-op.
- Normal cycle, checkpoint side:
  - ckpt_alloc & ckpt_ready: slot[tail] <= {sp, count, stack[sp-1]}, using the pre-op state of this cycle; tail+1; nck+1. Alloc when not ready is ignored.
  - ckpt_free & nck > 0: head+1, nck-1. Free when empty is ignored.
  - Alloc and free in the same cycle both apply; nck is unchanged.
- Recover cycle:
  - sp/count <= slot[recover_id].
  - tail <= recover_id, and nck is recomputed as (recover_id - head) mod NCKPT. The recovered slot and all younger slots are released.
  - push, pop, ckpt_alloc and ckpt_free are ignored; commit must stall that cycle.
  - With repair enabled and saved count > 0: stack[saved_sp-1] <= saved top.
- Arithmetic: sp and queue pointers wrap modulo their power-of-two range. count never exceeds DEPTH and never goes below 0.

## Timing
- Reset values: top_addr 0 (all entries cleared), top_valid 0, ckpt_ready 1, ckpt_id 0, overflow 0. sp, count, head, tail and nck are 0.
- top_addr and top_valid are combinational from registered state. There is no same-cycle bypass: a push in cycle N is visible at cycle N+1.
- ckpt_id and ckpt_ready are registered-state derived. ckpt_id is valid in the cycle of alloc and names the slot written at that edge.
- Recover takes effect at the edge. Restored top_addr and ckpt_id appear in cycle N+1.
- rst asserted mid-operation discards all stack and checkpoint state in one cycle.

## Configuration
- RAS_TOS_REPAIR_EN defined: slots store the top entry (AW bits each) and recover rewrites it. This repairs a top entry overwritten by a wrong-path push/pop pair or push.
- Not defined: slots store only {sp, count}. Recover restores pointers only, and the top field is not synthesised.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 -> top_addr 0x300, top_valid 1. Three pops -> top_valid 0. A fourth pop leaves sp and count unchanged.
- DEPTH=16: push 17 addresses 0x1000+4i -> count 16, overflow 1, top_addr 0x1040. 16 pops return 0x1040 down to 0x1004, then top_valid 0.
- Push 0xA0, alloc (id 0), pop, push 0xBB, recover id 0 -> next cycle top_addr 0xA0 with RAS_TOS_REPAIR_EN, 0xBB without. ckpt_id 0, ckpt_ready 1.
- NCKPT=8: 8 allocs -> ckpt_ready 0; a 9th alloc is ignored. Alloc+free in the same cycle when full -> ckpt_ready stays 0. A plain free -> ckpt_ready 1.
- Allocs ids 0..4, free twice (head 2), recover id 3 -> ckpt_id 3; nck 1 (only slot 2 live); slot 3 state restored.
- Assert push and ckpt_free during the recover cycle -> both ignored. Assert rst mid-sequence -> all outputs return to reset values next cycle.
